aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Iterative round sequencer for the AES encryption engine. It holds the 128-bit cipher state and performs the initial AddRoundKey itself. It then drives the combinational round datapath (subbytes → shiftrows → mixcolumns → addroundkey) once per clock for NR rounds, skipping MixColumns on the final round. It sits between the block-input interface and the shared round logic, and presents round indices to the external key-schedule store.

## Interface
- NR, 10, number of rounds; legal values 10, 12, 14
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  plaintext block offered
- in_ready  output  1  controller can accept a block
- in_block  input  128  plaintext; byte 0 at [127:120], column-major
- rk  input  128  round key for current rnd_idx; combinational from key store
- rnd_idx  output  4  round-key index requested
- dp_state  output  128  state register driven to round datapath
- dp_last  output  1  final round; datapath bypasses mixcolumns
- dp_result  input  128  combinational round result for dp_state with rk
- out_valid  output  1  ciphertext available
- out_ready  input  1  downstream accepts ciphertext
- out_block  output  128  ciphertext; equals state register

## Operation
- States: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1, rnd_idx=0.
  - On in_valid&&in_ready: state ← in_block ^ rk, rnd ← 1, go to ROUND.
- ROUND:
  - rnd_idx=rnd, dp_last=(rnd==NR), state ← dp_result each cycle.
  - If rnd==NR, go to DONE; otherwise rnd ← rnd+1.
- DONE:
  - out_valid=1, out_block=state, held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
- in_ready=0 in ROUND and DONE. Input is ignored there; no block is queued or dropped silently.
- dp_last=0 outside ROUND. rnd_idx=0 outside ROUND.
- Round counter is 4 bits and never exceeds NR. No wrap.
- in_valid with in_ready=0 has no effect on state. Upstream holds the block.

## Timing
- Reset (async assert, sync-released use):
  - state=IDLE, rnd=0, state register=0.
  - in_ready=1, out_valid=0, dp_last=0, rnd_idx=0, out_block=0.
- Accept at edge T.
- ROUND occupies edges T+1..T+NR.
- out_valid rises after edge T+NR: visible in cycle T+NR+1 (11 cycles for NR=10).
- out_ready already high: DONE lasts one cycle, IDLE re-entered next edge. Throughput is one block per NR+2 cycles.
- out_ready low: stall indefinitely; out_block and out_valid unchanged.
- rst_n low mid-ROUND or mid-DONE: immediate return to reset values. Partial block discarded. No out_valid pulse.
- rk and dp_result are sampled at the same edge as state update. The combinational path is rnd_idx → key store → rk → datapath → dp_result within one cycle.

## Test plan
- FIPS-197 C.1 (NR=10):
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, out_ready=1.
  - Required: out_block=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 11 cycles after accept.
- Round sequencing: during the same run, the checker records rnd_idx per cycle.
  - Required: 0 at accept, then 1..10.
  - Required: dp_last high only in the cycle rnd_idx=10.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid.
  - Required: out_valid and out_block stable, in_ready=0 throughout.
  - Required: release → IDLE next cycle.
- Back-to-back: two FIPS vectors offered continuously with out_ready=1.
  - Required: second accepted 12 cycles after first, both ciphertexts correct.
  - Required: in_valid during ROUND has no effect.
- Reset mid-op: assert rst_n=0 at round 5.
  - Required: all outputs return to reset values asynchronously.
  - Required: a fresh block afterwards encrypts correctly with no stale out_valid.
- NR=14: FIPS-197 C.3 key 00..1f, plaintext 00112233445566778899aabbccddeeff.
  - Required: out_block=8ea2b7ca516745bfeafc49904b496089, 15-cycle latency.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: holds the cipher state, applies the initial
// AddRoundKey and steps the external round datapath once per clock for NR rounds.
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] rk,
  output logic [3:0]   rnd_idx,
  output logic [127:0] dp_state,
  output logic         dp_last,
  input  logic [127:0] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block
);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_e;

  localparam logic [3:0] LAST_RND = 4'(NR);

  state_e         state_q, state_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [127:0]   blk_q, blk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    blk_d     = blk_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    dp_last   = 1'b0;
    rnd_idx   = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        // rnd_idx is 0 here, so rk carries the whitening key for the initial AddRoundKey
        if (in_valid) begin
          blk_d   = in_block ^ rk;
          rnd_d   = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        rnd_idx = rnd_q;
        blk_d   = dp_result;
        if (rnd_q == LAST_RND) begin
          dp_last = 1'b1;
          state_d = DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          rnd_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        rnd_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign dp_state  = blk_q;
  assign out_block = blk_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: supplies key store and round datapath behaviourally,
// and checks NR=10 and NR=14 instances against a plain AES reference.
module tb_aes_round_ctrl;

  logic clk;
  logic rst_n;

  logic         iv10, ir10, dl10, ov10, ordy10;
  logic [3:0]   ri10;
  logic [127:0] ib10, rk10, ds10, dr10, ob10;
  logic         iv14, ir14, dl14, ov14, ordy14;
  logic [3:0]   ri14;
  logic [127:0] ib14, rk14, ds14, dr14, ob14;

  logic [7:0]   sbox  [0:255];
  logic [127:0] tab10 [0:15];
  logic [127:0] tab14 [0:15];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int sel      = 0;

  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_round_ctrl #(.NR(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv10), .in_ready(ir10), .in_block(ib10),
    .rk(rk10), .rnd_idx(ri10), .dp_state(ds10), .dp_last(dl10), .dp_result(dr10),
    .out_valid(ov10), .out_ready(ordy10), .out_block(ob10)
  );

  aes_round_ctrl #(.NR(14)) dut14 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv14), .in_ready(ir14), .in_block(ib14),
    .rk(rk14), .rnd_idx(ri14), .dp_state(ds14), .dp_last(dl14), .dp_result(dr14),
    .out_valid(ov14), .out_ready(ordy14), .out_block(ob14)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [127:0] expand_key(input logic [255:0] key, input int nk, input int idx);
    logic [31:0] w [0:63];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 64; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction

  // One full AES round; byte i sits at row i%4, column i/4
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gm(a0, 8'd2) ^ gm(a1, 8'd3) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gm(a1, 8'd2) ^ gm(a2, 8'd3) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'd2) ^ gm(a3, 8'd3);
        t[4*c+3] = gm(a0, 8'd3) ^ a1 ^ a2 ^ gm(a3, 8'd2);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input int s);
    logic [127:0] st;
    int nr_v;
    nr_v = (s != 0) ? 14 : 10;
    st = pt ^ ((s != 0) ? tab14[0] : tab10[0]);
    for (int r = 1; r <= nr_v; r++)
      st = aes_round(st, (s != 0) ? tab14[r] : tab10[r], r == nr_v);
    return st;
  endfunction

  // Key store and round datapath seen by each controller
  always_comb rk10 = tab10[ri10];
  always_comb dr10 = aes_round(ds10, rk10, dl10);
  always_comb rk14 = tab14[ri14];
  always_comb dr14 = aes_round(ds14, rk14, dl14);

  function automatic logic get_ir(); return (sel != 0) ? ir14 : ir10; endfunction
  function automatic logic get_ov(); return (sel != 0) ? ov14 : ov10; endfunction
  function automatic logic get_dl(); return (sel != 0) ? dl14 : dl10; endfunction
  function automatic logic [3:0] get_ri(); return (sel != 0) ? ri14 : ri10; endfunction
  function automatic logic [127:0] get_ob(); return (sel != 0) ? ob14 : ob10; endfunction
  function automatic int cur_nr(); return (sel != 0) ? 14 : 10; endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_in(input logic v, input logic [127:0] b);
    if (sel != 0) begin iv14 = v; ib14 = b; end
    else begin iv10 = v; ib10 = b; end
  endtask

  task automatic set_ordy(input logic v);
    if (sel != 0) ordy14 = v;
    else ordy10 = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s nr=%0d got=%h exp=%h", tag, cur_nr(), got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    int keep;
    keep = sel;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      chk({tag, "_in_ready"},  128'(get_ir()), 128'(1));
      chk({tag, "_out_valid"}, 128'(get_ov()), 128'(0));
      chk({tag, "_dp_last"},   128'(get_dl()), 128'(0));
      chk({tag, "_rnd_idx"},   128'(get_ri()), 128'(0));
      chk({tag, "_out_block"}, get_ob(), 128'(0));
    end
    sel = keep;
  endtask

  // Offer one block, follow it through every round, stall the output, then release
  task automatic do_block(input logic [127:0] pt, input int stall,
                          output logic [127:0] ct_o, output int acc_cyc);
    logic [127:0] exp_ct;
    int nr_v, n;
    nr_v   = cur_nr();
    exp_ct = ref_encrypt(pt, sel);
    n = 0;
    set_in(1'b1, pt);
    while (get_ir() == 1'b0 && n < 50) begin
      step();
      n++;
    end
    chk("accept_wait", 128'(n < 50), 128'(1));
    chk("idle_rnd_idx",   128'(get_ri()), 128'(0));
    chk("idle_out_valid", 128'(get_ov()), 128'(0));
    chk("idle_dp_last",   128'(get_dl()), 128'(0));
    step();
    acc_cyc = cyc;
    for (int k = 1; k <= nr_v; k++) begin
      chk("round_rnd_idx",   128'(get_ri()), 128'(k));
      chk("round_dp_last",   128'(get_dl()), 128'(k == nr_v));
      chk("round_in_ready",  128'(get_ir()), 128'(0));
      chk("round_out_valid", 128'(get_ov()), 128'(0));
      set_in(1'($urandom_range(0, 1)), rand128());
      set_ordy(1'($urandom_range(0, 1)));
      step();
    end
    chk("done_out_valid", 128'(get_ov()), 128'(1));
    chk("done_in_ready",  128'(get_ir()), 128'(0));
    chk("ciphertext", get_ob(), exp_ct);
    ct_o = get_ob();
    for (int s = 0; s < stall; s++) begin
      set_ordy(1'b0);
      set_in(1'b1, rand128());
      step();
      chk("stall_out_valid", 128'(get_ov()), 128'(1));
      chk("stall_out_block", get_ob(), exp_ct);
      chk("stall_in_ready",  128'(get_ir()), 128'(0));
    end
    set_ordy(1'b1);
    set_in(1'b1, rand128());
    step();
    chk("release_in_ready",  128'(get_ir()), 128'(1));
    chk("release_out_valid", 128'(get_ov()), 128'(0));
  endtask

  initial begin
    logic [127:0] ct, ct2;
    int a1, a2;
    init_sbox();
    for (int i = 0; i < 15; i++) begin
      tab10[i] = expand_key({KEY_C1, 128'h0}, 4, i);
      tab14[i] = expand_key(KEY_C3, 8, i);
    end
    tab10[15] = '0;
    tab14[15] = '0;
    iv10 = 1'b0; ib10 = '0; ordy10 = 1'b1;
    iv14 = 1'b0; ib14 = '0; ordy14 = 1'b1;
    rst_n = 1'b0;
    #3;
    chk_reset("reset");
    #9;
    rst_n = 1'b1;
    step();

    sel = 0;
    do_block(PT_FIPS, 0, ct, a1);
    chk("fips_c1", ct, CT_C1);

    do_block(PT_FIPS, 20, ct, a1);
    chk("backpressure_fips", ct, CT_C1);

    do_block(PT_FIPS, 0, ct, a1);
    do_block(PT_FIPS, 0, ct2, a2);
    chk("b2b_gap", 128'(a2 - a1), 128'(12));
    chk("b2b_first", ct, CT_C1);
    chk("b2b_second", ct2, CT_C1);

    // Abort a block at round 5 with an asynchronous reset
    set_in(1'b1, PT_FIPS);
    step();
    set_in(1'b1, rand128());
    repeat (4) step();
    chk("mid_rnd_idx", 128'(get_ri()), 128'(5));
    #1 rst_n = 1'b0;
    #1 chk_reset("async_reset");
    set_in(1'b0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_reset_out_valid", 128'(get_ov()), 128'(0));
    chk("post_reset_in_ready",  128'(get_ir()), 128'(1));
    do_block(PT_FIPS, 0, ct, a1);
    chk("post_reset_fips", ct, CT_C1);

    for (int i = 0; i < 6; i++) do_block(rand128(), int'($urandom_range(0, 4)), ct, a1);
    set_in(1'b0, '0);

    sel = 1;
    do_block(PT_FIPS, 0, ct, a1);
    chk("fips_c3", ct, CT_C3);
    for (int i = 0; i < 3; i++) do_block(rand128(), int'($urandom_range(0, 4)), ct, a1);
    set_in(1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
